// File: rtl/pad_ctl_sequencer_if.sv
// Register port and commit handshake between the system bus master and the
// pad control sequencer.
interface pad_ctl_sequencer_if #(
  parameter int ADDR_W    = 8,
  parameter int PAD_CTL_W = 9
);
  logic                 cfg_wr;
  logic                 cfg_rd;
  logic [ADDR_W-1:0]    cfg_addr;
  logic [PAD_CTL_W-1:0] cfg_wdata;
  logic [PAD_CTL_W-1:0] cfg_rdata;
  logic                 cfg_rvalid;
  logic                 cfg_ready;
  logic                 cfg_err;
  logic                 commit_req;
  logic                 commit_done;
  logic                 busy;

  modport master (
    output cfg_wr, cfg_rd, cfg_addr, cfg_wdata, commit_req,
    input  cfg_rdata, cfg_rvalid, cfg_ready, cfg_err, commit_done, busy
  );

  modport slave (
    input  cfg_wr, cfg_rd, cfg_addr, cfg_wdata, commit_req,
    output cfg_rdata, cfg_rvalid, cfg_ready, cfg_err, commit_done, busy
  );
endinterface

// File: rtl/pad_ctl_sequencer.sv
// Pad control sequencer: software fills shadow words, a commit copies them to
// the active (pad-driving) words one pad at a time, STAGGER cycles apart.
// A pad whose driver turns on first gets its new word with OEN still set and
// only drops OEN one stagger slot later (break-before-make).
module pad_ctl_sequencer #(
  parameter int                   NUM_PADS  = 100,
  parameter int                   PAD_CTL_W = 9,
  parameter int                   STAGGER   = 4,
  parameter logic [PAD_CTL_W-1:0] RST_CTL   = 'h001,
  parameter int                   ADDR_W    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  pad_ctl_sequencer_if.slave                   bus,
  output logic [(NUM_PADS-3)*PAD_CTL_W-1:0]    pad_ctl
);
  localparam int NCTL = NUM_PADS - 3;
  localparam int W    = PAD_CTL_W;
  localparam int P_W  = (NCTL > 1) ? $clog2(NCTL) : 1;
  localparam int WC_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int A_W  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, DONE} state_t;

  state_t                  state, state_n;
  logic [P_W-1:0]          p, p_n;
  logic                    pend, pend_n;
  logic [WC_W-1:0]         wc, wc_n;
  logic [NCTL-1:0][W-1:0]  shadow, active;
  logic                    act_we;
  logic [W-1:0]            act_wd;
  logic [W-1:0]            sh_p, ac_p;
  logic                    last;
  logic                    busy;

  // address decode (one extra bit so 2*NCTL == 2**ADDR_W cannot wrap)
  logic [A_W-1:0]          a, a_ac;
  logic                    in_sh, in_ac;
  logic [P_W-1:0]          sh_idx, ac_idx;
  logic [W-1:0]            rd_val;
  logic                    wr_ok, rd_err, wr_err;

  assign a      = {1'b0, bus.cfg_addr};
  assign a_ac   = a - A_W'(NCTL);
  assign in_sh  = a < A_W'(NCTL);
  assign in_ac  = !in_sh && (a < A_W'(2*NCTL));
  assign sh_idx = P_W'(a);
  assign ac_idx = P_W'(a_ac);

  assign busy   = (state != IDLE);
  assign wr_ok  = bus.cfg_wr && !busy && in_sh;
  assign wr_err = bus.cfg_wr && !busy && !in_sh;
  assign rd_err = bus.cfg_rd && !in_sh && !in_ac;
  assign rd_val = in_sh ? shadow[sh_idx] : (in_ac ? active[ac_idx] : '0);

  assign sh_p = shadow[p];
  assign ac_p = active[p];
  assign last = (p == P_W'(NCTL-1));

  assign bus.busy        = busy;
  assign bus.cfg_ready   = !busy;
  assign bus.commit_done = (state == DONE);
  assign pad_ctl         = active;

  // FSM state, pad pointer, pending-OEN flag and stagger counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
      pend  <= 1'b0;
      wc    <= '0;
    end else begin
      state <= state_n;
      p     <= p_n;
      pend  <= pend_n;
      wc    <= wc_n;
    end
  end

  // next-state logic and active-word write request
  always_comb begin
    state_n = state;
    p_n     = p;
    pend_n  = pend;
    wc_n    = wc;
    act_we  = 1'b0;
    act_wd  = sh_p;
    unique case (state)
      IDLE: begin
        if (bus.commit_req) begin
          p_n     = '0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (sh_p == ac_p) begin
          if (last) state_n = DONE;
          else      p_n     = p + 1'b1;
        end else begin
          act_we  = 1'b1;
          wc_n    = WC_W'(STAGGER-1);
          state_n = WAIT;
          // driver turning on: load the word with OEN kept high first
          if (ac_p[0] && !sh_p[0]) begin
            act_wd = {sh_p[W-1:1], 1'b1};
            pend_n = 1'b1;
          end else begin
            pend_n = 1'b0;
          end
        end
      end
      WAIT: begin
        if (wc == '0) begin
          if (pend) begin
            act_we = 1'b1;
            act_wd = {ac_p[W-1:1], 1'b0};
            pend_n = 1'b0;
            wc_n   = WC_W'(STAGGER-1);
          end else if (last) begin
            state_n = DONE;
          end else begin
            p_n     = p + 1'b1;
            state_n = CHECK;
          end
        end else begin
          wc_n = wc - 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // shadow words: software-written, frozen while a commit runs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCTL; i++) shadow[i] <= RST_CTL;
    end else if (wr_ok) begin
      shadow[sh_idx] <= bus.cfg_wdata;
    end
  end

  // active words: only the sequencer updates them, one pad at a time
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCTL; i++) active[i] <= RST_CTL;
    end else if (act_we) begin
      active[p] <= act_wd;
    end
  end

  // registered read data and single-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cfg_rdata  <= '0;
      bus.cfg_rvalid <= 1'b0;
      bus.cfg_err    <= 1'b0;
    end else begin
      bus.cfg_rvalid <= bus.cfg_rd;
      bus.cfg_err    <= rd_err || wr_err;
      if (bus.cfg_rd) bus.cfg_rdata <= rd_val;
    end
  end
endmodule

// File: tb/tb_pad_ctl_sequencer.sv
// Bench for pad_ctl_sequencer (NUM_PADS=8 -> 5 controlled pads, STAGGER=4).
// A schedule-based model predicts every output each cycle; directed
// scenarios add literal expectations, then a random phase follows.
module tb_pad_ctl_sequencer;
  localparam int NP = 8;
  localparam int NC = NP - 3;
  localparam int W  = 9;
  localparam int S  = 4;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC*W-1:0] pad_ctl;

  pad_ctl_sequencer_if #(.ADDR_W(AW), .PAD_CTL_W(W)) bus ();

  pad_ctl_sequencer #(.NUM_PADS(NP), .PAD_CTL_W(W), .STAGGER(S),
                      .RST_CTL(9'h001), .ADDR_W(AW))
    dut (.clk(clk), .rst(rst), .bus(bus), .pad_ctl(pad_ctl));

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int c; int pad; logic [W-1:0] val; } ev_t;
  ev_t          evq[$];
  logic [W-1:0] m_sh[NC];
  logic [W-1:0] m_ac[NC];
  logic [W-1:0] m_rdata;
  bit           m_busy, m_done, m_rvalid, m_err, m_active;
  int           m_done_cyc;

  // advance the model across one clock edge using the inputs it sampled
  task automatic model_step();
    int a;
    bit ready;
    cyc++;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin m_sh[i] = 9'h001; m_ac[i] = 9'h001; end
      m_rdata = '0; m_rvalid = 0; m_err = 0; m_busy = 0; m_done = 0; m_active = 0;
      evq.delete();
    end else begin
      a = int'(bus.cfg_addr);
      ready = !m_busy;
      m_rvalid = bus.cfg_rd;
      m_err = (bus.cfg_rd && a >= 2*NC) || (bus.cfg_wr && ready && a >= NC);
      if (bus.cfg_rd) m_rdata = (a < NC) ? m_sh[a] : (a < 2*NC) ? m_ac[a-NC] : '0;
      if (bus.cfg_wr && ready && a < NC) m_sh[a] = bus.cfg_wdata;
      if (!m_busy && bus.commit_req) begin
        int c;
        c = cyc;
        for (int p = 0; p < NC; p++) begin
          if (m_sh[p] == m_ac[p]) c += 1;
          else if (m_ac[p][0] && !m_sh[p][0]) begin
            evq.push_back('{c+1, p, {m_sh[p][W-1:1], 1'b1}});
            evq.push_back('{c+1+S, p, m_sh[p]});
            c += 1 + 2*S;
          end else begin
            evq.push_back('{c+1, p, m_sh[p]});
            c += 1 + S;
          end
        end
        m_done_cyc = c;
        m_active = 1;
      end
      while (evq.size() > 0 && evq[0].c == cyc) begin
        m_ac[evq[0].pad] = evq[0].val;
        void'(evq.pop_front());
      end
      if (m_active && cyc > m_done_cyc) m_active = 0;
      m_busy = m_active;
      m_done = m_active && (cyc == m_done_cyc);
    end
    chk_en = 1'b1;
  endtask

  function automatic logic [NC*W-1:0] m_pads();
    logic [NC*W-1:0] v;
    for (int i = 0; i < NC; i++) v[i*W +: W] = m_ac[i];
    return v;
  endfunction

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pad_ctl", 64'(pad_ctl), 64'(m_pads()));
      chk("busy", 64'(bus.busy), 64'(m_busy));
      chk("cfg_ready", 64'(bus.cfg_ready), 64'(!m_busy));
      chk("commit_done", 64'(bus.commit_done), 64'(m_done));
      chk("cfg_rvalid", 64'(bus.cfg_rvalid), 64'(m_rvalid));
      chk("cfg_rdata", 64'(bus.cfg_rdata), 64'(m_rdata));
      chk("cfg_err", 64'(bus.cfg_err), 64'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_write(input int a, input logic [W-1:0] d);
    bus.cfg_wr = 1; bus.cfg_addr = AW'(a); bus.cfg_wdata = d;
    step();
    bus.cfg_wr = 0;
  endtask

  task automatic do_read(input int a);
    bus.cfg_rd = 1; bus.cfg_addr = AW'(a);
    step();
    bus.cfg_rd = 0;
  endtask

  int first_chg[NC], last_chg[NC];
  logic [W-1:0] first_val[NC];

  // pulse commit_req in cycle 0, return the cycle of commit_done
  task automatic run_commit(output int lat);
    int t0;
    logic [NC*W-1:0] prev;
    bit seen;
    for (int i = 0; i < NC; i++) begin first_chg[i] = -1; last_chg[i] = -1; first_val[i] = '0; end
    prev = pad_ctl;
    t0 = cyc;
    lat = -1;
    seen = 0;
    bus.commit_req = 1;
    step();
    bus.commit_req = 0;
    for (int k = 0; k < 500 && !seen; k++) begin
      for (int i = 0; i < NC; i++) begin
        if (pad_ctl[i*W +: W] !== prev[i*W +: W]) begin
          if (first_chg[i] < 0) begin first_chg[i] = cyc - t0; first_val[i] = pad_ctl[i*W +: W]; end
          last_chg[i] = cyc - t0;
        end
      end
      prev = pad_ctl;
      if (bus.commit_done) begin seen = 1; lat = cyc - t0; end
      else step();
    end
    if (!seen) chk("commit_timeout", 64'(0), 64'(1));
    step();
  endtask

  int lat, ndone;

  initial begin
    bus.cfg_wr = 0; bus.cfg_rd = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.commit_req = 0;
    rst = 1;
    step();
    step();
    rst = 0;

    // 1: reset state, read active word of pad 5
    chk("rst_pads", 64'(pad_ctl), 64'({NC{9'h001}}));
    chk("rst_ready", 64'(bus.cfg_ready), 64'(1));
    do_read(7);
    chk("rd7_valid", 64'(bus.cfg_rvalid), 64'(1));
    chk("rd7_data", 64'(bus.cfg_rdata), 64'h001);

    // 2: commit with nothing to change
    run_commit(lat);
    chk("nochg_done_cycle", 64'(lat), 64'(6));
    chk("nochg_pads", 64'(pad_ctl), 64'({NC{9'h001}}));

    // 3: driver turn-on on pad 4
    do_write(1, 9'h010);
    run_commit(lat);
    chk("bbm_done_cycle", 64'(lat), 64'(14));
    chk("bbm_first_val", 64'(first_val[1]), 64'h011);
    chk("bbm_gap", 64'(last_chg[1] - first_chg[1]), 64'(4));
    chk("bbm_final", 64'(pad_ctl[W +: W]), 64'h010);

    // 4: two pads change, staggered
    do_write(0, 9'h021);
    do_write(1, 9'h021);
    run_commit(lat);
    chk("two_done_cycle", 64'(lat), 64'(14));
    chk("two_gap_ge_stagger", 64'(first_chg[1] - first_chg[0] >= S), 64'(1));

    // 5: write and commit_req while busy are dropped, reads still served
    do_write(3, 9'h041);
    bus.commit_req = 1; step(); bus.commit_req = 0;
    step();
    chk("busy_ready_low", 64'(bus.cfg_ready), 64'(0));
    do_write(2, 9'h1f0);
    bus.commit_req = 1; step(); bus.commit_req = 0;
    do_read(2);
    chk("busy_rd2", 64'(bus.cfg_rdata), 64'h001);
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.commit_done) ndone++;
      step();
    end
    chk("one_done", 64'(ndone), 64'(1));
    do_read(2);
    chk("shadow2_kept", 64'(bus.cfg_rdata), 64'h001);

    // 6: reset in WAIT aborts commit; invalid write pulses cfg_err
    do_write(0, 9'h000);
    bus.commit_req = 1; step(); bus.commit_req = 0;
    step(); step(); step();
    rst = 1; step(); rst = 0;
    chk("abort_pads", 64'(pad_ctl), 64'({NC{9'h001}}));
    chk("abort_busy", 64'(bus.busy), 64'(0));
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.commit_done) ndone++;
      step();
    end
    chk("abort_no_done", 64'(ndone), 64'(0));
    do_write(12, 9'h0ff);
    chk("err_pulse", 64'(bus.cfg_err), 64'(1));
    step();
    chk("err_clear", 64'(bus.cfg_err), 64'(0));

    // random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      bus.cfg_wr     = ($urandom_range(0, 99) < 30);
      bus.cfg_rd     = ($urandom_range(0, 99) < 30);
      bus.cfg_addr   = AW'($urandom_range(0, 15));
      bus.cfg_wdata  = W'($urandom);
      bus.commit_req = ($urandom_range(0, 99) < 6);
      rst            = ($urandom_range(0, 999) < 3);
      step();
    end
    bus.cfg_wr = 0; bus.cfg_rd = 0; bus.commit_req = 0; rst = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
